// File: rtl/sr_rounder_if.sv
// sr_rounder_if: valid/ready bundle between the normaliser and the rounder.
// master = upstream/downstream driver side, slave = the rounding stage.
interface sr_rounder_if #(
  parameter int mant_width     = 23,
  parameter int exp_width      = 8,
  parameter int num_round_bits = 8
);
  logic                              in_valid;
  logic                              in_ready;
  logic                              in_sign;
  logic [mant_width+num_round_bits+1:0] in_mant;
  logic signed [exp_width+1:0]       in_exp;
  logic                              round_mode;
  logic                              out_valid;
  logic                              out_ready;
  logic [exp_width+mant_width:0]     out_result;
  logic                              out_overflow;
  logic                              out_inexact;

  modport master (
    output in_valid, in_sign, in_mant, in_exp, round_mode, out_ready,
    input  in_ready, out_valid, out_result, out_overflow, out_inexact
  );

  modport slave (
    input  in_valid, in_sign, in_mant, in_exp, round_mode, out_ready,
    output in_ready, out_valid, out_result, out_overflow, out_inexact
  );
endinterface

// File: rtl/sr_rounder.sv
// sr_rounder: two-stage RNE / stochastic rounding stage with LFSR.
// Ports: clk, rst (sync, high), bus (slave), seed_load, seed_value.
module sr_rounder #(
  parameter int mant_width     = 23,
  parameter int exp_width      = 8,
  parameter int num_round_bits = 8,
  parameter int min_exp        = -126,
  parameter int lfsr_width     = 32,
  parameter logic [lfsr_width-1:0] lfsr_seed = 32'hACE12468,
  parameter logic [lfsr_width-1:0] lfsr_taps = 32'h80200003
) (
  input  logic                  clk,
  input  logic                  rst,
  sr_rounder_if.slave           bus,
  input  logic                  seed_load,
  input  logic [lfsr_width-1:0] seed_value
);
  localparam int MW = mant_width;
  localparam int EW = exp_width;
  localparam int RB = num_round_bits;
  localparam int LW = lfsr_width;
  localparam int XW = EW + 2;
  localparam int PW = EW + MW;

  localparam logic signed [XW-1:0] BIAS = XW'(1 - min_exp);
  localparam logic signed [XW-1:0] EMAX = XW'((1 << EW) - 1);

  logic          s1_valid_q;
  logic          s1_sign_q;
  logic [EW-1:0] s1_exp_q;
  logic [MW-1:0] s1_frac_q;
  logic          s1_inc_q;
  logic          s1_ovf_q;
  logic          s1_inx_q;

  logic          out_valid_q;
  logic [PW:0]   out_result_q;
  logic          out_ovf_q;
  logic          out_inx_q;

  logic [LW-1:0] lfsr_q;
  logic [LW-1:0] lfsr_d;

  logic s2_ready;
  logic s1_adv;
  logic in_fire;

  assign s2_ready    = !out_valid_q || bus.out_ready;
  assign s1_adv      = s1_valid_q && s2_ready;
  assign bus.in_ready = !s1_valid_q || s2_ready;
  assign in_fire     = bus.in_valid && bus.in_ready;

  // Stage 1: exponent bias, overflow pre-check, increment decision
  logic signed [XW-1:0] biased;
  logic                 is_zero;
  logic [RB-1:0]        rnd;
  logic [MW-1:0]        frac;
  logic [RB:0]          sr_sum;
  logic                 rne_inc;
  logic                 inc_d;
  logic                 pre_ovf_d;
  logic [EW-1:0]        exp_d;

  always_comb begin
    biased    = bus.in_exp + BIAS;
    is_zero   = (bus.in_mant == '0);
    rnd       = bus.in_mant[RB-1:0];
    frac      = bus.in_mant[MW+RB-1:RB];
    sr_sum    = {1'b0, rnd} + {1'b0, lfsr_q[RB-1:0]};
    rne_inc   = rnd[RB-1] && ((|rnd[RB-2:0]) || frac[0]);
    inc_d     = bus.round_mode ? sr_sum[RB] : rne_inc;
    pre_ovf_d = !is_zero && (biased >= EMAX);
    exp_d     = is_zero ? '0 : biased[EW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
    end else if (in_fire) begin
      s1_valid_q <= 1'b1;
    end else if (s1_adv) begin
      s1_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_sign_q <= bus.in_sign;
      s1_exp_q  <= exp_d;
      s1_frac_q <= frac;
      s1_inc_q  <= inc_d;
      s1_ovf_q  <= pre_ovf_d;
      s1_inx_q  <= |rnd;
    end
  end

  // Stage 2: fraction carry ripples into the exponent, which handles
  // subnormal promotion and mantissa overflow without a shift.
  logic [PW-1:0] packed_sum;
  logic          ovf2;
  logic [PW:0]   res_d;

  always_comb begin
    packed_sum = {s1_exp_q, s1_frac_q} + PW'(s1_inc_q);
    ovf2       = s1_ovf_q || (&packed_sum[PW-1:MW]);
    res_d      = {s1_sign_q, packed_sum};
    if (ovf2) begin
      res_d = {s1_sign_q, {EW{1'b1}}, {MW{1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_ovf_q    <= 1'b0;
      out_inx_q    <= 1'b0;
    end else if (s2_ready) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_result_q <= res_d;
        out_ovf_q    <= ovf2;
        out_inx_q    <= s1_inx_q;
      end
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_result   = out_result_q;
  assign bus.out_overflow = out_ovf_q;
  assign bus.out_inexact  = out_inx_q;

  // Galois LFSR, right-shifting; load wins over advance
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[LW-1:1]};
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ lfsr_taps;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= lfsr_seed;
    end else if (seed_load) begin
      lfsr_q <= (seed_value == '0) ? lfsr_seed : seed_value;
    end else if (in_fire) begin
      lfsr_q <= lfsr_d;
    end
  end
endmodule
